// File: rtl/compare_req_pkg.sv
// Shared definitions for the compare_requester slice: FSM state encoding,
// responder result encodings and the counter width used by the guard and
// timeout counters.
package compare_req_pkg;

  // Width of the guard and timeout counters.
  localparam int CNT_W = 8;

  // Requester FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_REQ    = 2'd2,
    ST_RETURN = 2'd3
  } state_e;

  // Legal responder results as {bigger, equal, smaller}.
  localparam logic [2:0] RES_BIGGER  = 3'b100;
  localparam logic [2:0] RES_EQUAL   = 3'b010;
  localparam logic [2:0] RES_SMALLER = 3'b001;

  // True when the result is exactly one of the three legal encodings.
  function automatic logic res_is_one_hot(input logic [2:0] res);
    return (res == RES_BIGGER) || (res == RES_EQUAL) || (res == RES_SMALLER);
  endfunction

endpackage

// File: rtl/compare_requester_sync_bit.sv
// sync_bit: multi-flop synchronizer for a single asynchronous level.
// The chain is synchronously cleared so a stale level does not survive reset.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/compare_requester.sv
// compare_requester: clocked initiator for the asynchronous req/fin compare
// handshake. Accepts an operand pair, presents it to the responder, waits for
// the synchronized fin (after a guard window that flushes a stale fin), and
// returns the captured result on a valid/ready stream.
// Optional feature macro: COMPARE_REQUESTER_TIMEOUT_EN adds a REQ timeout that
// completes the transaction with out_err=1 and an all-zero result.
module compare_requester
  import compare_req_pkg::*;
#(
  parameter int unsigned Width       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GUARD       = 3,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  // operand stream
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_x,
  input  logic [Width-1:0] in_y,
  // responder side
  output logic             req,
  output logic [Width-1:0] x,
  output logic [Width-1:0] y,
  input  logic             fin,
  input  logic             bigger,
  input  logic             equal,
  input  logic             smaller,
  // result stream
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bigger,
  output logic             out_equal,
  output logic             out_smaller,
  output logic             out_err
);

  // Parameter sanity checks at elaboration.
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("compare_requester: SYNC_STAGES must be at least 2");
  end
  if ((GUARD < SYNC_STAGES + 1) || (GUARD > 255)) begin : g_chk_guard
    $error("compare_requester: GUARD must be in SYNC_STAGES+1..255");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_chk_timeout
    $error("compare_requester: TIMEOUT must be in 1..255");
  end

  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

  logic fin_sync;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_fin_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (fin),
    .q_o  (fin_sync)
  );

  state_e           state_q, state_d;
  logic [Width-1:0] x_q, x_d;
  logic [Width-1:0] y_q, y_d;
  logic             req_q, req_d;
  logic [2:0]       res_q, res_d;
  logic             err_q, err_d;
  logic             ovld_q, ovld_d;
  logic [CNT_W-1:0] guard_q, guard_d;
  logic             guard_done;
  logic [2:0]       res_in;

`ifdef COMPARE_REQUESTER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] to_q, to_d;
`endif

  // Guard expires once it has counted GUARD REQ cycles; it saturates there.
  assign guard_done = (guard_q >= GUARD_C);
  assign res_in     = {bigger, equal, smaller};

  // Next-state logic for the handshake FSM, operand and result registers.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    req_d   = req_q;
    res_d   = res_q;
    err_d   = err_q;
    ovld_d  = ovld_q;
    guard_d = guard_q;
`ifdef COMPARE_REQUESTER_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Operands have had a full cycle to settle; raise the request now.
        req_d   = 1'b1;
        guard_d = '0;
`ifdef COMPARE_REQUESTER_TIMEOUT_EN
        to_d    = '0;
`endif
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!guard_done) begin
          guard_d = guard_q + 1'b1;
        end
        if (guard_done && fin_sync) begin
          res_d   = res_in;
          err_d   = !res_is_one_hot(res_in);
          req_d   = 1'b0;
          ovld_d  = 1'b1;
          state_d = ST_RETURN;
        end
`ifdef COMPARE_REQUESTER_TIMEOUT_EN
        else if (to_q == TIMEOUT_C) begin
          // Responder never answered: complete with an error and no result.
          res_d   = '0;
          err_d   = 1'b1;
          req_d   = 1'b0;
          ovld_d  = 1'b1;
          state_d = ST_RETURN;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      ST_RETURN: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      req_q   <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      ovld_q  <= 1'b0;
      guard_q <= '0;
`ifdef COMPARE_REQUESTER_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      req_q   <= req_d;
      res_q   <= res_d;
      err_q   <= err_d;
      ovld_q  <= ovld_d;
      guard_q <= guard_d;
`ifdef COMPARE_REQUESTER_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign req         = req_q;
  assign x           = x_q;
  assign y           = y_q;
  assign out_valid   = ovld_q;
  assign out_bigger  = res_q[2];
  assign out_equal   = res_q[1];
  assign out_smaller = res_q[0];
  assign out_err     = err_q;

endmodule

// File: doc/compare_requester.md
# compare_requester

Clocked initiator for the asynchronous req/fin compare handshake. It accepts operand pairs on a valid/ready stream, drives `x`/`y`/`req` into a comparator-style responder, synchronizes the returned `fin`, captures `bigger`/`equal`/`smaller`, and presents the result on an output valid/ready stream. It is the bridge between clocked flow-control logic and the asynchronous compare responder.

## Interface
- `Width`, 32, operand width
- `SYNC_STAGES`, 2, flops in the `fin` synchronizer (≥2)
- `GUARD`, 3, cycles after `req` rise during which `fin_sync` is ignored (≥ `SYNC_STAGES`+1)
- `TIMEOUT`, 255, max cycles from `req` rise to captured `fin` (8-bit counter, 1..255)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  high only in IDLE
- `in_x`, `in_y`  in  Width  operands
- `req`  out  1  request to responder, registered
- `x`, `y`  out  Width  operands to responder, registered, stable while `req`=1
- `fin`  in  1  responder done, asynchronous
- `bigger`, `equal`, `smaller`  in  1  responder result, stable while `fin`=1
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumed
- `out_bigger`, `out_equal`, `out_smaller`  out  1  captured result
- `out_err`  out  1  timeout or non-one-hot result

## Operation
- States: IDLE, SETUP, REQ, RETURN.
- IDLE: `in_ready`=1. On `in_valid`: latch `in_x`/`in_y` into `x`/`y`, go to SETUP.
- SETUP, one cycle: `req` stays 0, so operands settle before the request edge. Then set `req`=1, clear the guard and timeout counters, and go to REQ.
- REQ: `req`=1. The guard counter runs for GUARD cycles. After the guard expires, the first cycle with `fin_sync`=1 does the following:
  - register `bigger`/`equal`/`smaller` into `out_*`;
  - set `out_err` = result not exactly one-hot;
  - set `req`=0 and `out_valid`=1;
  - go to RETURN.
- RETURN: hold `out_*`, `out_err` and `out_valid` until `out_ready`=1. Then clear `out_valid` and go to IDLE. `req` is already 0, so there is at least one `req`-low cycle between requests.
- The guard is required because the responder does not clear `fin` on `req` fall. The previous `fin`=1 is still in the synchronizer at `req` rise and is flushed by the guard.
- Reset (`rst_n`=0 on any clock edge, including mid-REQ):
  - state goes to IDLE;
  - `req`, `x`, `y`, `out_*`, `out_valid` and `out_err` go to 0;
  - synchronizer and counters are cleared;
  - any in-flight compare is abandoned. The responder's stale `fin` is handled by the guard on the next request.
- `in_ready` is 0 outside IDLE. A new operand is never accepted while a result is pending.

## Timing
- Reset values:
  - `in_ready`=1;
  - all other outputs 0.
- Latency with an ideal responder (`fin` rises within the `req`-rise cycle):
  - accept in cycle 0;
  - `x`/`y` valid in cycle 1;
  - `req`=1 in cycle 2;
  - earliest `fin_sync` sample in cycle 2+GUARD;
  - `out_valid`=1 in cycle 3+GUARD (cycle 6 at defaults).
- `req` falls in the same cycle `out_valid` rises.
- `x`/`y` change only in IDLE on acceptance.
- `out_ready` held high: RETURN lasts 1 cycle, and IDLE accepts in the next cycle.

## Configuration
- `COMPARE_REQUESTER_TIMEOUT_EN` defined:
  - The timeout counter counts REQ cycles from `req` rise.
  - If it reaches TIMEOUT without capture: `req`=0, `out_bigger`/`out_equal`/`out_smaller`=0, `out_err`=1, `out_valid`=1, go to RETURN.
  - A `fin` arriving later is ignored (flushed by the next guard).
- `COMPARE_REQUESTER_TIMEOUT_EN` undefined:
  - There is no timeout counter; REQ waits indefinitely.
  - `out_err` reflects the one-hot check only.

## Structure
- Package `compare_req_pkg`:
  - state enum (IDLE, SETUP, REQ, RETURN);
  - result-encoding constants (RES_BIGGER=3'b100, RES_EQUAL=3'b010, RES_SMALLER=3'b001);
  - counter width constant (8).
- Sub-module `sync_bit` (parameter STAGES): multi-flop synchronizer for `fin`, synchronously cleared by `rst_n`.
- FSM, counters and registers are in `compare_requester`.

## Test plan
- Basic compare:
  - stimulus: `in_x`=5, `in_y`=3, ideal responder model, `out_ready`=1;
  - required: `out_bigger`=1, `out_err`=0, `out_valid` in cycle 6 after accept;
  - then `in_x`=3, `in_y`=5 → `out_smaller`=1; `in_x`=`in_y`=32'hFFFF_FFFF → `out_equal`=1.
- Stale `fin`:
  - stimulus: the responder keeps `fin`=1 from the previous op, drops it at `req` rise, and raises it 4 cycles later with the new result;
  - required: the new result is captured, never the old one.
- Backpressure:
  - stimulus: `out_ready`=0 for 10 cycles;
  - required: `out_*` stable, `in_ready`=0 throughout, `req`=0;
  - on `out_ready` → IDLE next cycle.
- Non-one-hot:
  - stimulus: the responder returns 3'b110;
  - required: `out_err`=1, `out_bigger`=1, `out_equal`=1.
- Timeout (macro defined, TIMEOUT=20):
  - stimulus: `fin` never rises;
  - required: `out_valid`=1, all result bits 0, `out_err`=1, at cycle 2+20+1.
- Reset mid-REQ:
  - stimulus: `rst_n`=0 for one cycle while waiting;
  - required: `req`=0 and all outputs 0 next cycle, `in_ready`=1;
  - the next op completes correctly.
